// File: rtl/way_replace_counter_pkg.sv
// Shared LC-3b types for the replacement-counter slice: the datapath word and
// the counter end-of-range policy.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    REPL_WRAP = 1'b0,
    REPL_SAT  = 1'b1
  } lc3b_replace_mode_t;

endpackage

// File: rtl/way_replace_counter_capture_mux.sv
// Combinational one-hot source select: AND-OR mux plus one-hot / multi-hot flags.
// Unselected sources are masked by AND, so an X on them cannot reach the output.
module onehot_capture_mux
  import lc3b_types::*;
#(
  parameter int NUM_SRC = 4
) (
  input  lc3b_word           i_datain [NUM_SRC],
  input  logic [NUM_SRC-1:0] i_sel,
  output lc3b_word           o_word,
  output logic               o_valid,
  output logic               o_multi
);

  logic w_any;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first; a path that leaves a variable unassigned infers a latch.
  always_comb begin
    o_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      o_word = o_word | (i_datain[i] & {16{i_sel[i]}});
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_any   = |i_sel;
  assign o_multi = |(i_sel & (i_sel - 1'b1));
  assign o_valid = w_any & ~o_multi;

endmodule

// File: rtl/way_replace_counter.sv
// Per-set round-robin victim-way counters (wrap or saturate) with load/clamp,
// plus a registered one-hot data capture with multi-select error pulse.
module way_replace_counter
  import lc3b_types::*;
#(
  parameter  int NUM_WAYS = 4,
  parameter  int NUM_SETS = 8,
  parameter  int NUM_SRC  = 4,
  parameter  int SATURATE = 0,
  localparam int CTR_W    = $clog2(NUM_WAYS),
  localparam int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SET_W-1:0]   set_idx,
  input  logic               inc,
  input  logic               load,
  input  logic [CTR_W-1:0]   load_value,
  output logic [CTR_W-1:0]   ctr_value,
  output logic               at_max,
  input  lc3b_word           datain [NUM_SRC],
  input  logic [NUM_SRC-1:0] sel,
  output lc3b_word           data_out,
  output logic               sel_err
);

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(NUM_WAYS - 1);
  localparam lc3b_replace_mode_t MODE = (SATURATE != 0) ? REPL_SAT : REPL_WRAP;

  logic [CTR_W-1:0] r_ctr [NUM_SETS];
  lc3b_word         r_data_out;
  logic             r_sel_err;

  logic             w_set_ok;
  logic [CTR_W-1:0] w_cur;
  logic [CTR_W-1:0] w_load_clamped;
  logic [CTR_W-1:0] w_next;
  logic             w_wr_en;
  lc3b_word         w_mux_word;
  logic             w_mux_valid;
  logic             w_mux_multi;

  // Range checks only exist when the index/value width can exceed the legal range.
  if (NUM_SETS == (1 << SET_W)) begin : g_set_full
    assign w_set_ok = 1'b1;
  end else begin : g_set_part
    assign w_set_ok = (32'(set_idx) < NUM_SETS);
  end

  if (NUM_WAYS == (1 << CTR_W)) begin : g_ld_full
    assign w_load_clamped = load_value;
  end else begin : g_ld_part
    assign w_load_clamped = (load_value > CTR_MAX) ? CTR_MAX : load_value;
  end

  assign w_cur     = w_set_ok ? r_ctr[set_idx] : '0;
  assign ctr_value = w_cur;
  assign at_max    = (w_cur == CTR_MAX);

  always_comb begin
    w_next  = w_cur;
    w_wr_en = 1'b0;
    if (w_set_ok) begin
      if (load) begin
        w_next  = w_load_clamped;
        w_wr_en = 1'b1;
      end else if (inc) begin
        w_wr_en = 1'b1;
        if (w_cur != CTR_MAX) begin
          w_next = w_cur + 1'b1;
        end else if (MODE == REPL_WRAP) begin
          w_next = '0;
        end
      end
    end
  end

  // NOTE: the counter array is a small register file that must power up at way 0,
  // so every entry is reset here rather than left as an unreset memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        r_ctr[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_ctr[set_idx] <= w_next;
    end
  end

  onehot_capture_mux #(
    .NUM_SRC (NUM_SRC)
  ) u_capture_mux (
    .i_datain (datain),
    .i_sel    (sel),
    .o_word   (w_mux_word),
    .o_valid  (w_mux_valid),
    .o_multi  (w_mux_multi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
      r_sel_err  <= 1'b0;
    end else begin
      if (w_mux_valid) begin
        r_data_out <= w_mux_word;
      end
      r_sel_err <= w_mux_multi;
    end
  end

  assign data_out = r_data_out;
  assign sel_err  = r_sel_err;

endmodule

// File: tb/tb_way_replace_counter.sv
// Randomised + directed bench: a wrap-mode 4-way instance and a saturate-mode
// 3-way instance, both checked against an integer-arithmetic reference model.
module tb_way_replace_counter;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  lc3b_word   datain [4];
  logic [3:0] sel = '0;

  logic [2:0] a_set = '0, b_set = '0;
  logic       a_inc = 1'b0, a_load = 1'b0, b_inc = 1'b0, b_load = 1'b0;
  logic [1:0] a_lv = '0, b_lv = '0;
  logic [1:0] a_ctr, b_ctr;
  logic       a_max, b_max;
  lc3b_word   a_data, b_data;
  logic       a_err, b_err;

  int m_a [8];
  int m_b [8];
  int m_data;
  int m_err;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  way_replace_counter #(.NUM_WAYS(4), .NUM_SETS(8), .NUM_SRC(4), .SATURATE(0)) u_dut_a (
    .clk(clk), .reset(reset), .set_idx(a_set), .inc(a_inc), .load(a_load),
    .load_value(a_lv), .ctr_value(a_ctr), .at_max(a_max),
    .datain(datain), .sel(sel), .data_out(a_data), .sel_err(a_err)
  );

  way_replace_counter #(.NUM_WAYS(3), .NUM_SETS(8), .NUM_SRC(4), .SATURATE(1)) u_dut_b (
    .clk(clk), .reset(reset), .set_idx(b_set), .inc(b_inc), .load(b_load),
    .load_value(b_lv), .ctr_value(b_ctr), .at_max(b_max),
    .datain(datain), .sel(sel), .data_out(b_data), .sel_err(b_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_a[i] = 0;
      m_b[i] = 0;
    end
    m_data = 0;
    m_err  = 0;
  endfunction

  // Reference rules: wrap is modulo arithmetic, saturate/clamp are min().
  function automatic void model_edge();
    int lv, ones, idx;
    if (a_load) begin
      lv = int'(a_lv);
      m_a[a_set] = (lv > 3) ? 3 : lv;
    end else if (a_inc) begin
      m_a[a_set] = (m_a[a_set] + 1) % 4;
    end
    if (b_load) begin
      lv = int'(b_lv);
      m_b[b_set] = (lv > 2) ? 2 : lv;
    end else if (b_inc) begin
      m_b[b_set] = (m_b[b_set] + 1 > 2) ? 2 : m_b[b_set] + 1;
    end
    ones = $countones(sel);
    idx  = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
    if (ones == 1) m_data = int'(datain[idx]);
    m_err = (ones > 1) ? 1 : 0;
  endfunction

  task automatic check_comb();
    check("a_ctr", int'(a_ctr), m_a[a_set]);
    check("a_max", int'(a_max), (m_a[a_set] == 3) ? 1 : 0);
    check("b_ctr", int'(b_ctr), m_b[b_set]);
    check("b_max", int'(b_max), (m_b[b_set] == 2) ? 1 : 0);
  endtask

  task automatic check_regs();
    check("a_data", int'(a_data), m_data);
    check("a_err",  int'(a_err),  m_err);
    check("b_data", int'(b_data), m_data);
    check("b_err",  int'(b_err),  m_err);
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic cycle();
    #1 check_comb();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle_ctl();
    a_inc = 1'b0; a_load = 1'b0; b_inc = 1'b0; b_load = 1'b0;
  endtask

  initial begin
    datain[0] = 16'hBEEF; datain[1] = 16'h0F0F; datain[2] = 16'h1234; datain[3] = 16'hAAAA;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state, every set
    for (int i = 0; i < 8; i++) begin
      a_set = 3'(i); b_set = 3'(i);
      #1 check_comb();
    end
    check_regs();
    reset = 1'b0;

    // Set 3 wraps 1,2,3,0,1; set 2 untouched
    a_set = 3'd3; a_inc = 1'b1;
    repeat (5) cycle();
    a_inc = 1'b0;
    #1 check("a_set3_after5", int'(a_ctr), 1);
    a_set = 3'd2;
    #1 check("a_set2_idle", int'(a_ctr), 0);

    // Saturating 3-way: 1,2,2,2
    b_set = 3'd0; b_inc = 1'b1;
    repeat (4) cycle();
    b_inc = 1'b0;
    #1 check("b_sat_hold", int'(b_ctr), 2);

    // Load beats inc; out-of-range load clamps
    a_set = 3'd5; a_load = 1'b1; a_inc = 1'b1; a_lv = 2'd2;
    b_set = 3'd5; b_load = 1'b1; b_inc = 1'b1; b_lv = 2'd2;
    cycle();
    b_lv = 2'd3; b_inc = 1'b0; a_load = 1'b0; a_inc = 1'b0;
    cycle();
    b_load = 1'b0;
    #1 check("b_load_clamp", int'(b_ctr), 2);

    // Capture: one-hot, none, multi (pulse lasts one cycle), X on unselected source
    sel = 4'b0100; cycle();
    check("cap_sel2", int'(a_data), 16'h1234);
    sel = 4'b0000; datain[2] = 16'h5555; cycle();
    sel = 4'b0110; cycle();
    check("multi_pulse", int'(a_err), 1);
    sel = 4'b0000; cycle();
    check("multi_clear", int'(a_err), 0);
    sel = 4'b1000; datain[0] = 'x; cycle();
    datain[0] = 16'hBEEF;

    // Async reset mid-operation with inc pending on set 1 at value 2
    sel = 4'b0000; a_set = 3'd1; a_inc = 1'b1;
    repeat (2) cycle();
    #1 check("a_set1_pre", int'(a_ctr), 2);
    #2 reset = 1'b1;
    model_reset();
    #1 check("a_async_clr", int'(a_ctr), 0);
    @(posedge clk);
    @(negedge clk);
    check_regs();
    reset = 1'b0; idle_ctl();
    cycle();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      a_set  = 3'($urandom_range(0, 7));
      b_set  = 3'($urandom_range(0, 7));
      a_inc  = 1'($urandom_range(0, 1));
      b_inc  = 1'($urandom_range(0, 1));
      a_load = ($urandom_range(0, 5) == 0);
      b_load = ($urandom_range(0, 5) == 0);
      a_lv   = 2'($urandom_range(0, 3));
      b_lv   = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) datain[i] = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       sel = 4'b0000;
        1, 2:    sel = 4'(1 << $urandom_range(0, 3));
        default: sel = 4'($urandom_range(0, 15));
      endcase
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
